// File: rtl/mci_sram_ecc_model.sv
// Behavioural single-port SRAM with side-band ECC storage.
// Word addressed, per-byte write enables, a fixed-latency pipelined read
// path with a valid strobe, read-side error injection (optionally written
// back), out-of-range detection and saturating access counters.
// Each word is stored as {ecc, data}; the ECC bits are opaque to this model.
module mci_sram_ecc_model #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 7,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int RD_LATENCY = 1,
    parameter bit INIT_VAL   = 1'b0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            cs_i,
    input  logic                            we_i,
    input  logic [ADDR_WIDTH-1:0]           addr_i,
    input  logic [DATA_WIDTH/8-1:0]         wbe_i,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0] wdata_i,
    input  logic                            err_inj_en_i,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0] err_inj_mask_i,
    input  logic                            err_inj_sticky_i,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0] rdata_o,
    output logic                            rvalid_o,
    output logic                            oob_err_o,
    output logic [31:0]                     rd_cnt_o,
    output logic [31:0]                     wr_cnt_o
);

    localparam int WORD_W = DATA_WIDTH + ECC_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    // Storage array. It has no reset: contents start at INIT_VAL and
    // survive rst_ni so a bench can reset the controller without losing data.
    logic [WORD_W-1:0] mem_q [DEPTH] = '{default: {WORD_W{INIT_VAL}}};

    logic              rd_req;
    logic              wr_req;
    logic              addr_oob;
    logic [WORD_W-1:0] stored_word;
    logic [WORD_W-1:0] inj_word;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] wr_word;
    logic              sticky_wb;

    logic [31:0]       rd_cnt_q;
    logic [31:0]       wr_cnt_q;
    logic              oob_q;

    // Read pipeline: stage 0 captures at the request edge, the last stage
    // drives the outputs.
    logic              pipe_vld_q [RD_LATENCY];
    logic [WORD_W-1:0] pipe_dat_q [RD_LATENCY];

    assign rd_req   = cs_i & ~we_i;
    assign wr_req   = cs_i & we_i;
    // Only reachable when DEPTH is not a power of two.
    assign addr_oob = (32'(addr_i) >= 32'(DEPTH));

    assign stored_word = mem_q[addr_i];
    // Injection only ever modifies the read path; writes ignore it.
    assign inj_word    = stored_word ^ (err_inj_en_i ? err_inj_mask_i : '0);
    assign rd_word     = addr_oob ? '0 : inj_word;
    assign sticky_wb   = rd_req & err_inj_en_i & err_inj_sticky_i & ~addr_oob;

    // Merge enabled bytes into the stored word; ECC only on full-word writes.
    always_comb begin
        wr_word = stored_word;
        for (int b = 0; b < NBYTES; b++) begin
            if (wbe_i[b]) begin
                wr_word[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
        if (&wbe_i) begin
            wr_word[WORD_W-1:DATA_WIDTH] = wdata_i[WORD_W-1:DATA_WIDTH];
        end
    end

    // Array update: normal writes, or write-back of a sticky corrupted read.
    always_ff @(posedge clk_i) begin
        if (wr_req && !addr_oob) begin
            mem_q[addr_i] <= wr_word;
        end else if (sticky_wb) begin
            mem_q[addr_i] <= inj_word;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_rd_pipe
            logic              in_vld;
            logic [WORD_W-1:0] in_dat;

            if (gi == 0) begin : g_head
                assign in_vld = rd_req;
                assign in_dat = rd_word;
            end else begin : g_tail
                assign in_vld = pipe_vld_q[gi-1];
                assign in_dat = pipe_dat_q[gi-1];
            end

            // Stage register; data only moves with a valid so the last stage holds.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    pipe_vld_q[gi] <= 1'b0;
                    pipe_dat_q[gi] <= '0;
                end else begin
                    pipe_vld_q[gi] <= in_vld;
                    if (in_vld) begin
                        pipe_dat_q[gi] <= in_dat;
                    end
                end
            end
        end
    endgenerate

    // Out-of-range pulse, one cycle after the offending request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oob_q <= 1'b0;
        end else begin
            oob_q <= cs_i & addr_oob;
        end
    end

    // Saturating access counters; out-of-range requests still count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_req && (rd_cnt_q != 32'hFFFF_FFFF)) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (wr_req && (wr_cnt_q != 32'hFFFF_FFFF)) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign rvalid_o  = pipe_vld_q[RD_LATENCY-1];
    assign rdata_o   = pipe_dat_q[RD_LATENCY-1];
    assign oob_err_o = oob_q;
    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;

endmodule

// File: tb/tb_mci_sram_ecc_model.sv
// Bench for mci_sram_ecc_model: two instances share one stimulus stream
// (A: DEPTH=48, RD_LATENCY=3; B: DEPTH=64, RD_LATENCY=2). A reference model
// built from arrays and a due-cycle schedule predicts every output each cycle;
// directed table vectors, reset and back-to-back sequences add explicit checks.
module tb_mci_sram_ecc_model;

    localparam int WW = 39;
    localparam int AW = 6;
    localparam int DEPTHS [2] = '{48, 64};
    localparam int LATS   [2] = '{3, 2};

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          cs_i = 1'b0;
    logic          we_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [3:0]    wbe_i = '0;
    logic [WW-1:0] wdata_i = '0;
    logic          err_inj_en_i = 1'b0;
    logic [WW-1:0] err_inj_mask_i = '0;
    logic          err_inj_sticky_i = 1'b0;

    logic [WW-1:0] a_rdata, b_rdata;
    logic          a_rvalid, b_rvalid, a_oob, b_oob;
    logic [31:0]   a_rd_cnt, a_wr_cnt, b_rd_cnt, b_wr_cnt;

    int err_cnt = 0;
    int chk_cnt = 0;
    bit chk_en  = 1'b0;

    always #5 clk_i = ~clk_i;

    mci_sram_ecc_model #(.DEPTH(48), .DATA_WIDTH(32), .ECC_WIDTH(7), .RD_LATENCY(3)) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .cs_i(cs_i), .we_i(we_i), .addr_i(addr_i),
        .wbe_i(wbe_i), .wdata_i(wdata_i), .err_inj_en_i(err_inj_en_i),
        .err_inj_mask_i(err_inj_mask_i), .err_inj_sticky_i(err_inj_sticky_i),
        .rdata_o(a_rdata), .rvalid_o(a_rvalid), .oob_err_o(a_oob),
        .rd_cnt_o(a_rd_cnt), .wr_cnt_o(a_wr_cnt));

    mci_sram_ecc_model #(.DEPTH(64), .DATA_WIDTH(32), .ECC_WIDTH(7), .RD_LATENCY(2)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .cs_i(cs_i), .we_i(we_i), .addr_i(addr_i),
        .wbe_i(wbe_i), .wdata_i(wdata_i), .err_inj_en_i(err_inj_en_i),
        .err_inj_mask_i(err_inj_mask_i), .err_inj_sticky_i(err_inj_sticky_i),
        .rdata_o(b_rdata), .rvalid_o(b_rvalid), .oob_err_o(b_oob),
        .rd_cnt_o(b_rd_cnt), .wr_cnt_o(b_wr_cnt));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WW-1:0] m_mem [2][64];
    bit            m_sv  [2][256];
    logic [WW-1:0] m_sd  [2][256];
    logic          m_rvalid [2];
    logic [WW-1:0] m_rdata  [2];
    logic          m_oob    [2];
    logic [31:0]   m_rd [2];
    logic [31:0]   m_wr [2];
    int            m_cyc;

    task automatic model_clear();
        m_cyc = 0;
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 256; s++) m_sv[k][s] = 1'b0;
            m_rvalid[k] = 1'b0;
            m_rdata[k]  = '0;
            m_oob[k]    = 1'b0;
            m_rd[k]     = '0;
            m_wr[k]     = '0;
        end
    endtask

    task automatic model_step();
        bit            oob;
        logic [WW-1:0] w;
        int            slot;
        m_cyc++;
        for (int k = 0; k < 2; k++) begin
            oob = cs_i && (int'(addr_i) >= DEPTHS[k]);
            m_oob[k] = oob;
            if (cs_i && we_i) begin
                if (m_wr[k] != 32'hFFFF_FFFF) m_wr[k] = m_wr[k] + 1;
                if (!oob) begin
                    w = m_mem[k][addr_i];
                    for (int b = 0; b < 4; b++)
                        if (wbe_i[b]) w[b*8 +: 8] = wdata_i[b*8 +: 8];
                    if (wbe_i == 4'hF) w[38:32] = wdata_i[38:32];
                    m_mem[k][addr_i] = w;
                end
            end else if (cs_i) begin
                if (m_rd[k] != 32'hFFFF_FFFF) m_rd[k] = m_rd[k] + 1;
                w = oob ? '0 : (m_mem[k][addr_i] ^ (err_inj_en_i ? err_inj_mask_i : '0));
                if (err_inj_en_i && err_inj_sticky_i && !oob) m_mem[k][addr_i] = w;
                slot = (m_cyc + LATS[k] - 1) % 256;
                m_sv[k][slot] = 1'b1;
                m_sd[k][slot] = w;
            end
            slot = m_cyc % 256;
            if (m_sv[k][slot]) begin
                m_rvalid[k] = 1'b1;
                m_rdata[k]  = m_sd[k][slot];
                m_sv[k][slot] = 1'b0;
            end else begin
                m_rvalid[k] = 1'b0;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 64; a++) m_mem[k][a] = '0;
        model_clear();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) model_clear();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk_i);
            if (chk_en) begin
                check("a_rvalid", 64'(a_rvalid), 64'(m_rvalid[0]));
                check("a_rdata",  64'(a_rdata),  64'(m_rdata[0]));
                check("a_oob",    64'(a_oob),    64'(m_oob[0]));
                check("a_rd_cnt", 64'(a_rd_cnt), 64'(m_rd[0]));
                check("a_wr_cnt", 64'(a_wr_cnt), 64'(m_wr[0]));
                check("b_rvalid", 64'(b_rvalid), 64'(m_rvalid[1]));
                check("b_rdata",  64'(b_rdata),  64'(m_rdata[1]));
                check("b_oob",    64'(b_oob),    64'(m_oob[1]));
                check("b_rd_cnt", 64'(b_rd_cnt), 64'(m_rd[1]));
                check("b_wr_cnt", 64'(b_wr_cnt), 64'(m_wr[1]));
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          we;
        bit [AW-1:0] addr;
        bit [3:0]    wbe;
        bit [WW-1:0] wdata;
        bit          inj;
        bit [WW-1:0] mask;
        bit          sticky;
        bit [WW-1:0] exp;      // expected read data on instance A
        bit          exp_oob;  // expected oob pulse on instance A
    } vec_t;

    function automatic vec_t mk(bit we, int addr, bit [3:0] wbe, bit [WW-1:0] wd, bit inj,
                                bit [WW-1:0] mask, bit sticky, bit [WW-1:0] exp, bit oob);
        vec_t v;
        v.we = we; v.addr = AW'(addr); v.wbe = wbe; v.wdata = wd; v.inj = inj;
        v.mask = mask; v.sticky = sticky; v.exp = exp; v.exp_oob = oob;
        return v;
    endfunction

    task automatic drive_idle();
        cs_i = 1'b0; we_i = 1'b0; addr_i = '0; wbe_i = '0; wdata_i = '0;
        err_inj_en_i = 1'b0; err_inj_mask_i = '0; err_inj_sticky_i = 1'b0;
    endtask

    // One request, then wait (bounded) for the read return on instance A.
    task automatic op(input vec_t v, input int idx);
        bit got;
        int lat;
        got = 1'b0;
        lat = -1;
        @(posedge clk_i); #1;
        cs_i = 1'b1; we_i = v.we; addr_i = v.addr; wbe_i = v.wbe; wdata_i = v.wdata;
        err_inj_en_i = v.inj; err_inj_mask_i = v.mask; err_inj_sticky_i = v.sticky;
        @(posedge clk_i); #1;
        drive_idle();
        @(negedge clk_i);
        check($sformatf("vec%0d_oob", idx), 64'(a_oob), 64'(v.exp_oob));
        if (!v.we) begin
            for (int n = 0; n < 8 && !got; n++) begin
                if (n > 0) @(negedge clk_i);
                if (a_rvalid) begin
                    got = 1'b1;
                    lat = n;
                end
            end
            check($sformatf("vec%0d_rvalid_seen", idx), 64'(got), 64'd1);
            if (got) begin
                check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(LATS[0] - 1));
                check($sformatf("vec%0d_rdata", idx), 64'(a_rdata), 64'(v.exp));
            end
        end
        $display("op %0d: %s addr=%0d wbe=%h wdata=%h inj=%0d sticky=%0d rdata=%h oob=%0d",
                 idx, v.we ? "WR" : "RD", v.addr, v.wbe, v.wdata, v.inj, v.sticky, a_rdata, a_oob);
    endtask

    task automatic pulse_reset();
        @(negedge clk_i); #2;
        rst_ni = 1'b0;
        @(negedge clk_i); #2;
        rst_ni = 1'b1;
    endtask

    localparam int NV = 21;
    vec_t vt [NV];

    initial begin
        logic [13:0]   a_hist, b_hist;
        logic [63:0]   r64;
        logic [WW-1:0] rmask;

        vt[0]  = mk(1, 5,  4'hF, {7'h2A, 32'hDEADBEEF}, 0, '0, 0, '0, 0);
        vt[1]  = mk(0, 5,  4'h0, '0, 0, '0, 0, {7'h2A, 32'hDEADBEEF}, 0);
        vt[2]  = mk(1, 5,  4'h2, {7'h55, 32'h0000_1100}, 0, '0, 0, '0, 0);
        vt[3]  = mk(0, 5,  4'h0, '0, 0, '0, 0, {7'h2A, 32'hDEAD11EF}, 0);
        vt[4]  = mk(0, 5,  4'h0, '0, 1, 39'h1, 0, {7'h2A, 32'hDEAD11EE}, 0);
        vt[5]  = mk(0, 5,  4'h0, '0, 0, '0, 0, {7'h2A, 32'hDEAD11EF}, 0);
        vt[6]  = mk(0, 5,  4'h0, '0, 1, 39'h1, 1, {7'h2A, 32'hDEAD11EE}, 0);
        vt[7]  = mk(0, 5,  4'h0, '0, 0, '0, 0, {7'h2A, 32'hDEAD11EE}, 0);
        vt[8]  = mk(1, 50, 4'hF, {7'h7F, 32'hFFFF_FFFF}, 0, '0, 0, '0, 1);
        vt[9]  = mk(0, 50, 4'h0, '0, 0, '0, 0, '0, 1);
        vt[10] = mk(1, 47, 4'hF, {7'h01, 32'h1234_5678}, 0, '0, 0, '0, 0);
        vt[11] = mk(0, 47, 4'h0, '0, 0, '0, 0, {7'h01, 32'h1234_5678}, 0);
        vt[12] = mk(0, 0,  4'h0, '0, 0, '0, 0, '0, 0);
        vt[13] = mk(1, 5,  4'h0, {7'h7F, 32'hFFFF_FFFF}, 0, '0, 0, '0, 0);
        vt[14] = mk(0, 5,  4'h0, '0, 0, '0, 0, {7'h2A, 32'hDEAD11EE}, 0);
        vt[15] = mk(1, 6,  4'hF, {7'h00, 32'h0000_00AA}, 1, {WW{1'b1}}, 1, '0, 0);
        vt[16] = mk(0, 6,  4'h0, '0, 1, 39'h40_0000_0000, 0, {7'h40, 32'h0000_00AA}, 0);
        vt[17] = mk(1, 5,  4'hF, {7'h11, 32'hCAFE_F00D}, 0, '0, 0, '0, 0);
        vt[18] = mk(0, 5,  4'h0, '0, 0, '0, 0, {7'h11, 32'hCAFE_F00D}, 0);
        vt[19] = mk(1, 5,  4'h8, {7'h00, 32'hAB00_0000}, 0, '0, 0, '0, 0);
        vt[20] = mk(0, 5,  4'h0, '0, 0, '0, 0, {7'h11, 32'hABFE_F00D}, 0);

        drive_idle();
        #2 rst_ni = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk_i);
        check("reset_a_rdata",  64'(a_rdata),  64'd0);
        check("reset_a_rvalid", 64'(a_rvalid), 64'd0);
        check("reset_a_rd_cnt", 64'(a_rd_cnt), 64'd0);
        #3 rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) op(vt[i], i);

        // Reset while a read is in flight: the return must be dropped.
        @(posedge clk_i); #1;
        cs_i = 1'b1; we_i = 1'b0; addr_i = AW'(5);
        @(posedge clk_i); #1;
        drive_idle();
        #2 rst_ni = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk_i);
            check("rst_a_rvalid", 64'(a_rvalid), 64'd0);
            check("rst_b_rvalid", 64'(b_rvalid), 64'd0);
            check("rst_a_rdata",  64'(a_rdata),  64'd0);
            check("rst_a_wr_cnt", 64'(a_wr_cnt), 64'd0);
            check("rst_b_rd_cnt", 64'(b_rd_cnt), 64'd0);
        end
        #3 rst_ni = 1'b1;
        $display("reset mid-read: in-flight read dropped, counters a_rd=%0d a_wr=%0d", a_rd_cnt, a_wr_cnt);
        op(mk(0, 5, 4'h0, '0, 0, '0, 0, {7'h11, 32'hABFE_F00D}, 0), 100);

        // Back-to-back reads of addresses 0..7 straight after a reset.
        pulse_reset();
        a_hist = '0;
        b_hist = '0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk_i); #1;
            if (i < 8) begin
                cs_i = 1'b1; we_i = 1'b0; addr_i = AW'(i);
            end else begin
                drive_idle();
            end
            @(negedge clk_i);
            a_hist[i] = a_rvalid;
            b_hist[i] = b_rvalid;
        end
        check("b2b_b_pulses", 64'(b_hist), 64'(14'h03FC));
        check("b2b_a_pulses", 64'(a_hist), 64'(14'h07F8));
        check("b2b_b_rd_cnt", 64'(b_rd_cnt), 64'd8);
        check("b2b_a_rd_cnt", 64'(a_rd_cnt), 64'd8);
        $display("back-to-back: a_hist=%b b_hist=%b rd_cnt a=%0d b=%0d", a_hist, b_hist, a_rd_cnt, b_rd_cnt);

        // Randomised traffic, checked every cycle against the model.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_i); #1;
            r64 = {$urandom, $urandom};
            rmask = ($urandom_range(0, 1) == 1) ? (39'd1 << $urandom_range(0, 38)) : r64[38:0];
            cs_i = ($urandom_range(0, 9) < 7);
            we_i = $urandom_range(0, 1) == 1;
            addr_i = AW'($urandom_range(0, 63));
            wbe_i = 4'($urandom_range(0, 15));
            r64 = {$urandom, $urandom};
            wdata_i = r64[38:0];
            err_inj_en_i = ($urandom_range(0, 4) == 0);
            err_inj_mask_i = rmask;
            err_inj_sticky_i = $urandom_range(0, 1) == 1;
            if (cs_i)
                $display("rand %0d: %s addr=%0d wbe=%h wdata=%h inj=%0d sticky=%0d",
                         i, we_i ? "WR" : "RD", addr_i, wbe_i, wdata_i, err_inj_en_i, err_inj_sticky_i);
        end
        @(posedge clk_i); #1;
        drive_idle();
        repeat (6) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
